// File: rtl/nand_mux_pipeline_if.sv
// Handshake and bundle signals of nand_mux_pipeline. The master side is the bundle source plus the
// downstream sink. The slave side is the unit itself.
interface nand_mux_pipeline_if #(
  parameter int unsigned N = 10
) ();
  localparam int unsigned OnesW = $clog2(N + 1);

  logic             valid_i;
  logic             ready_o;
  logic [N-1:0]     x_i;
  logic [N-1:0]     y_i;
  logic             valid_o;
  logic             ready_i;
  logic [N-1:0]     z_o;
  logic [OnesW-1:0] z_ones_o;
  logic             z_major_o;

  modport master (
    output valid_i, x_i, y_i, ready_i,
    input  ready_o, valid_o, z_o, z_ones_o, z_major_o
  );

  modport slave (
    input  valid_i, x_i, y_i, ready_i,
    output ready_o, valid_o, z_o, z_ones_o, z_major_o
  );
endinterface

// File: rtl/nand_mux_pipeline.sv
// Pipelined NAND-multiplexing unit: one executive stage and STAGES-1 restorative stages.
// Each stage has an LFSR that drives the bundle rotations. NAND_MUX_ERROR_INJECT_EN adds gate flips.
module nand_mux_pipeline #(
  parameter int unsigned N          = 10,
  parameter int unsigned STAGES     = 1,
  parameter logic [31:0] LFSR_SEED  = 32'hACE1_2024,
  parameter int unsigned ERR_THRESH = 0
) (
  input logic                clk,
  input logic                reset_n,
  nand_mux_pipeline_if.slave bus
);
  localparam int unsigned R        = $clog2(N);
  localparam int unsigned OnesW    = $clog2(N + 1);
  localparam logic [31:0] LfsrTaps = 32'h8020_0003;

  // Galois form, taps 32,22,2,1
  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return l[0] ? ((l >> 1) ^ LfsrTaps) : (l >> 1);
  endfunction

  function automatic logic [31:0] seed_of(input int unsigned s);
    logic [31:0] sd;
    sd = LFSR_SEED ^ (32'(s) * 32'h9E37_79B9);
    return (sd == 32'd0) ? 32'd1 : sd;
  endfunction

  // Fold raw LFSR bits into the range 0..N-1; r < 2^R < 2N so one subtraction suffices
  function automatic logic [R-1:0] rot_amt(input logic [R-1:0] r);
    logic [R-1:0] amt;
    amt = r;
    if (32'(r) >= N) amt = R'(32'(r) - N);
    return amt;
  endfunction

  function automatic logic [N-1:0] rotl(input logic [N-1:0] v, input logic [R-1:0] amt);
    return N'(({v, v} << amt) >> N);
  endfunction

  function automatic logic [OnesW-1:0] popcnt(input logic [N-1:0] v);
    logic [OnesW-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) c = c + OnesW'(v[i]);
    return c;
  endfunction

`ifdef NAND_MUX_ERROR_INJECT_EN
  localparam logic [16:0] ErrThr = 17'(ERR_THRESH);

  // Gate i compares bits [15:0] of the stage LFSR rotated right by i
  function automatic logic [N-1:0] err_mask(input logic [31:0] l);
    logic [N-1:0] m;
    logic [15:0]  e;
    for (int i = 0; i < N; i++) begin
      e    = 16'({l, l} >> (i % 32));
      m[i] = {1'b0, e} < ErrThr;
    end
    return m;
  endfunction
`else
  logic unused_err_thresh;
  assign unused_err_thresh = ^17'(ERR_THRESH);
`endif

  logic         en;
  logic [N-1:0] stage_data     [STAGES];
  logic [N-1:0] stage_gate     [STAGES];
  logic         stage_valid    [STAGES];
  logic         stage_in_valid [STAGES];

  // The whole pipeline advances together; it freezes only while the output is blocked
  assign en = ~stage_valid[STAGES-1] | bus.ready_i;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic [N-1:0] op_a, op_b;
    logic [N-1:0] a_rot, b_rot;
    logic [N-1:0] gate_d;
    logic [N-1:0] data_q;
    logic [31:0]  lfsr_q;
    logic         in_valid;
    logic         valid_q;

    if (s == 0) begin : g_exec
      assign op_a     = bus.x_i;
      assign op_b     = bus.y_i;
      assign in_valid = bus.valid_i;
    end else begin : g_rest
      assign op_a     = stage_data[s-1];
      assign op_b     = stage_data[s-1];
      assign in_valid = stage_valid[s-1];
    end

    assign a_rot = rotl(op_a, rot_amt(lfsr_q[R-1:0]));
    assign b_rot = rotl(op_b, rot_amt(lfsr_q[2*R-1:R]));

`ifdef NAND_MUX_ERROR_INJECT_EN
    assign gate_d = ~(a_rot & b_rot) ^ err_mask(lfsr_q);
`else
    assign gate_d = ~(a_rot & b_rot);
`endif

    // The LFSR steps only on captured beats, so bubbles leave the sequence untouched
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        valid_q <= 1'b0;
        data_q  <= '0;
        lfsr_q  <= seed_of(s);
      end else if (en) begin
        valid_q <= in_valid;
        if (in_valid) begin
          data_q <= gate_d;
          lfsr_q <= lfsr_step(lfsr_q);
        end
      end
    end

    assign stage_data[s]     = data_q;
    assign stage_gate[s]     = gate_d;
    assign stage_valid[s]    = valid_q;
    assign stage_in_valid[s] = in_valid;
  end

  logic [OnesW-1:0] ones_d, ones_q;
  logic             major_d, major_q;

  // Statistics are registered with the last stage so they always match z_o
  assign ones_d  = popcnt(stage_gate[STAGES-1]);
  assign major_d = (32'(ones_d) << 1) > N;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ones_q  <= '0;
      major_q <= 1'b0;
    end else if (en && stage_in_valid[STAGES-1]) begin
      ones_q  <= ones_d;
      major_q <= major_d;
    end
  end

  assign bus.ready_o   = en;
  assign bus.valid_o   = stage_valid[STAGES-1];
  assign bus.z_o       = stage_data[STAGES-1];
  assign bus.z_ones_o  = ones_q;
  assign bus.z_major_o = major_q;
endmodule

// File: doc/nand_mux_pipeline.md
# nand_mux_pipeline

Parametrised, pipelined NAND-multiplexing unit. It accepts a pair of N-wire bundles and passes them through STAGES cascaded multiplexing stages: one executive stage followed by STAGES-1 restorative stages. Each stage applies a pseudo-random bundle permutation, then a NAND per wire, then an optional injected gate error. It sits between the bundle source and the bundle decision/statistics logic, uses a valid/ready handshake on both sides, and reports the ones-count and majority decision of the output bundle.

## Interface
- N, 10, bundle width (wires per bundle), 2..256
- STAGES, 1, pipeline stages; stage 0 is executive, stages 1..STAGES-1 are restorative; 1..8
- LFSR_SEED, 32'hACE1_2024, seed of stage s LFSR is LFSR_SEED ^ (s*32'h9E37_79B9); a zero result is replaced by 1
- ERR_THRESH, 0, 17-bit error threshold in 0..65536; per-gate flip probability is ERR_THRESH/65536
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- valid_i  in  1  input bundle pair valid
- ready_o  out  1  unit can accept a beat
- x_i  in  N  bundle X
- y_i  in  N  bundle Y
- valid_o  out  1  output bundle valid
- ready_i  in  1  downstream accepts the output
- z_o  out  N  output bundle
- z_ones_o  out  $clog2(N+1)  count of ones in z_o
- z_major_o  out  1  1 when 2*z_ones_o > N

## Operation
- Each stage s holds a data register, a valid bit v[s], and a 32-bit Galois LFSR L[s] (taps 32,22,2,1). Rotation width is R=$clog2(N).
- Rotation amount: take the low R bits of L[s] as r. If r >= N, use r-N; otherwise use r. X uses bits [R-1:0] and Y uses bits [2R-1:R].
- Executive stage 0: a = rotl(x_i, rx) and b = rotl(y_i, ry). Then g[i] = ~(a[i] & b[i]).
- Restorative stage s>0: both operands come from the stage s-1 bundle, with independent rotations rx and ry. Then g[i] = ~(a[i] & b[i]).
- Error: for gate i, take e = rotr(L[s], i)[15:0]. The stored bit is g[i] ^ (e < ERR_THRESH). This only applies when compiled in.
- Global enable: en = ~valid_o | ready_i. ready_o = en.
- When en is high:
  - v[0] <= valid_i, and v[s] <= v[s-1].
  - Each stage with a valid input captures its new data.
  - L[s] advances exactly once for each beat that stage s captures.
- When en is low, every register and LFSR holds.
- z_o is the last stage register and valid_o = v[STAGES-1].
- z_ones_o and z_major_o are registered alongside z_o in the last stage. They always describe the current z_o.
- Reset values:
  - all v = 0, so valid_o = 0
  - z_o = 0, z_ones_o = 0, z_major_o = 0
  - ready_o = 1 in the first cycle after reset
  - LFSRs reload their seeds

## Timing
- Latency is STAGES cycles from an accepted input beat (valid_i & ready_o) to valid_o. Throughput is one beat per cycle.
- Stall: while valid_o=1 and ready_i=0, z_o, z_ones_o and z_major_o hold stable, ready_o=0, and no beat is lost or duplicated.
- An output transfer and an input acceptance in the same cycle are legal and required for full throughput.
- Pipeline bubbles (valid_i=0) propagate as v=0. Bubbles do not advance LFSRs.
- Reset asserted mid-stream drops all in-flight beats. valid_o is 0 on the next edge.
- Data and LFSR sequences are fully deterministic from reset for a given accepted-beat sequence.

## Configuration
- NAND_MUX_ERROR_INJECT_EN defined: error XOR active per ERR_THRESH. ERR_THRESH=65536 inverts every gate output; ERR_THRESH=0 gives an ideal gate.
- Not defined: the error logic is absent, gates are ideal regardless of ERR_THRESH, and the LFSRs are used only for rotation.

## Test plan
- N=10, STAGES=1, ERR_THRESH=0: x=y=10'h3FF -> z_o=0, z_ones_o=0, z_major_o=0, one cycle after acceptance.
- N=10, STAGES=1: x=0, y=10'h3FF for 20 beats -> every z_o=10'h3FF, z_ones_o=10, z_major_o=1. x=10'h001, y=10'h3FF -> z_ones_o=9 for any rotation.
- N=10, STAGES=3: x=y=10'h3FF -> z_o=0 after exactly 3 cycles. x=y=0 -> z_o=10'h3FF. Back-to-back beats appear on consecutive cycles.
- Backpressure: hold ready_i=0 for 4 cycles with valid_o=1 -> z_o stable, ready_o=0. The output sequence after release matches the no-stall run beat for beat.
- With NAND_MUX_ERROR_INJECT_EN:
  - ERR_THRESH=65536, x=y=10'h3FF, STAGES=1 -> z_o=10'h3FF.
  - ERR_THRESH=6554 over 10000 beats -> mean flip rate 0.10 ± 0.01.
- Reset pulse with 2 beats in flight (STAGES=3) -> valid_o=0 next cycle, no stale beat emitted, LFSR sequence restarts identically.
